// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bus between the fetch unit, the combinational instruction memory and the
// datapath.
//
//   pc        fetch unit -> memory    instruction address (6 bits)
//   instr_in  memory -> fetch unit    instruction word at pc, same cycle
//   ir        fetch unit -> datapath  instruction register
//   ir_valid  fetch unit -> datapath  high in EXEC cycles
//   br_zero   datapath -> fetch unit  register ir[12:10] is zero
//   stall     datapath -> fetch unit  hold the fetch unit in EXEC
//   halted    fetch unit -> outside   high in HALT
//   retired   fetch unit -> outside   retired instruction count
//
// Modports: master is the fetch unit side, slave is the memory/datapath side.
interface fetch_unit_if;
    logic [5:0]  pc;
    logic [15:0] instr_in;
    logic [15:0] ir;
    logic        ir_valid;
    logic        br_zero;
    logic        stall;
    logic        halted;
    logic [15:0] retired;

    modport master (
        output pc, ir, ir_valid, halted, retired,
        input  instr_in, br_zero, stall
    );

    modport slave (
        input  pc, ir, ir_valid, halted, retired,
        output instr_in, br_zero, stall
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Two-cycle FETCH/EXEC instruction sequencer with a terminal HALT state.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset
//   bus   fetch_unit_if.master (pc, instr_in, ir, ir_valid, br_zero, stall,
//         halted, retired)
//
// Opcodes live in ir[15:13]: 3'b110 is a branch taken when br_zero is high,
// 3'b011 halts, everything else simply advances pc by one.
//
// Configuration macro: RETIRE_COUNT_EN. When defined, retired counts every
// instruction that leaves EXEC without a stall (the halt included). When not
// defined, retired is tied to zero and no counter register exists.
module fetch_unit (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_BRANCH = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b011;

    state_t      state;
    state_t      next_state;
    logic [5:0]  pc_q;
    logic [5:0]  pc_next;
    logic [15:0] ir_q;
    logic [15:0] ir_next;
    logic [2:0]  opcode;

    assign opcode = ir_q[15:13];

    // State, pc and ir registers. Reset wins over everything, including a
    // stalled EXEC or HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc_q  <= 6'd0;
            ir_q  <= 16'h0000;
        end else begin
            state <= next_state;
            pc_q  <= pc_next;
            ir_q  <= ir_next;
        end
    end

    // Next-state logic. FETCH latches the memory word; EXEC resolves the
    // instruction unless stalled. The branch adds only ir[5:0] because the
    // sign-extended 10-bit offset reduced mod 64 is exactly those bits, so
    // the 6-bit add wraps the same way. HALT holds everything until reset.
    always_comb begin
        next_state = state;
        pc_next    = pc_q;
        ir_next    = ir_q;
        case (state)
            FETCH: begin
                ir_next    = bus.instr_in;
                next_state = EXEC;
            end
            EXEC: begin
                if (!bus.stall) begin
                    if (opcode == OP_HALT) begin
                        next_state = HALT;
                    end else begin
                        if ((opcode == OP_BRANCH) && bus.br_zero) begin
                            pc_next = pc_q + ir_q[5:0];
                        end else begin
                            pc_next = pc_q + 6'd1;
                        end
                        next_state = FETCH;
                    end
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = (state == EXEC);
    assign bus.halted   = (state == HALT);

`ifdef RETIRE_COUNT_EN
    logic [15:0] retired_q;
    logic        retire;

    assign retire = (state == EXEC) && !bus.stall;

    // Retired counter: one tick per unstalled EXEC exit, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 16'h0000;
        end else if (retire) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = 16'h0000;
`endif

endmodule
